sram_like_responder: RTL and testbench

Responder end of the CPU's SRAM-like request interface (req/addr/addr_ok/data_ok). Accepts read and write requests from a fetch or memory stage, drives a 1-cycle-latency synchronous block RAM, and returns in-order responses with up to DEPTH requests outstanding. An optional LFSR injects pseudo-random addr_ok/data_ok stalls so that pipeline handshake corner cases get exercised in simulation.

---
 rtl/sram_like_responder_pkg.sv | 23 ++
 rtl/sram_like_responder_if.sv | 29 ++
 rtl/sram_like_responder_fifo.sv | 67 ++++++
 rtl/sram_like_responder.sv | 102 ++++++++++
 tb/tb_sram_like_responder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_like_responder_pkg
// Brief   : Shared types, LFSR constants and LFSR step for the SRAM-like responder.
// Revision: 1.0 - initial release
// ============================================================================
package sram_like_responder_pkg;

    localparam logic [15:0] SRAM_LIKE_LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] SRAM_LIKE_LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
    } resp_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & SRAM_LIKE_LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_like_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : sram_like_responder_if
// Brief   : SRAM-like request/response bundle (req/addr/addr_ok/data_ok).
// Revision: 1.0 - initial release
// ============================================================================
interface sram_like_responder_if;

    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic [31:0] rdata;
    logic        data_ok;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, rdata, data_ok
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, rdata, data_ok
    );

endinterface
`default_nettype wire

// File: rtl/sram_like_responder_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sram_resp_fifo
// Brief   : DEPTH x 33-bit synchronous response FIFO; push accepted when full if popping.
// Revision: 1.0 - initial release
// ============================================================================
module sram_resp_fifo
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 3
)
(
    input  logic  clk,
    input  logic  reset,
    input  logic  push_i,
    input  resp_t push_data_i,
    input  logic  pop_i,
    output logic  head_valid_o,
    output resp_t head_data_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    resp_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_like_responder.sv
`default_nettype none
// ============================================================================
// Module  : sram_like_responder
// Brief   : SRAM-like responder driving a 1-cycle block RAM, in-order responses.
// Revision: 1.0 - initial release
// ============================================================================
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 3,
    parameter bit          RAND_EN = 1'b0,
    parameter logic [15:0] SEED    = SRAM_LIKE_LFSR_SEED
)
(
    input  logic                        clk,
    input  logic                        reset,
    sram_like_responder_if.slave        bus,
    output logic                        ram_en_o,
    output logic [3:0]                  ram_wen_o,
    output logic [31:0]                 ram_addr_o,
    output logic [31:0]                 ram_wdata_o,
    input  logic [31:0]                 ram_rdata_i
);

    localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic             cap_q;
    logic             cap_wr_q;

    logic  a_stall;
    logic  d_stall;
    logic  addr_ok;
    logic  accept;
    logic  data_ok;
    logic  head_valid;
    resp_t head_data;
    resp_t push_data;

    assign a_stall = RAND_EN && lfsr_q[0];
    assign d_stall = RAND_EN && lfsr_q[1];
    assign lfsr_d  = lfsr_next(lfsr_q);

    // addr_ok looks only at registered state, never at req.
    assign addr_ok = !reset && (cnt_q < DEPTH_C) && !a_stall;
    assign accept  = bus.req && addr_ok;
    assign data_ok = !reset && head_valid && !d_stall;

    assign bus.addr_ok = addr_ok;
    assign bus.data_ok = data_ok;
    assign bus.rdata   = data_ok ? head_data.data : 32'h0;

    assign ram_en_o    = accept;
    assign ram_wen_o   = (accept && bus.wr) ? bus.wstrb : 4'h0;
    assign ram_addr_o  = bus.addr;
    assign ram_wdata_o = bus.wdata;

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, data_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            lfsr_q   <= SEED;
            cap_q    <= 1'b0;
            cap_wr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            cap_q    <= accept;
            cap_wr_q <= bus.wr;
        end
    end

    // RAM read data is valid the cycle after issue; writes respond with zero.
    assign push_data.wr   = cap_wr_q;
    assign push_data.data = cap_wr_q ? 32'h0 : ram_rdata_i;

    sram_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (cap_q),
        .push_data_i  (push_data),
        .pop_i        (data_ok),
        .head_valid_o (head_valid),
        .head_data_o  (head_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_like_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_like_responder
// Brief   : Directed bench: DEPTH=3 no-stall instance and DEPTH=2 stall-injected instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_like_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;

    sram_like_responder_if bus0 ();
    sram_like_responder_if bus1 ();

    logic        ram_en0, ram_en1;
    logic [3:0]  ram_wen0, ram_wen1;
    logic [31:0] ram_addr0, ram_addr1;
    logic [31:0] ram_wdata0, ram_wdata1;
    logic [31:0] ram_rdata0, ram_rdata1;

    sram_like_responder #(.DEPTH(3), .RAND_EN(1'b0), .SEED(16'hACE1)) dut0 (
        .clk         (clk),
        .reset       (rst0),
        .bus         (bus0),
        .ram_en_o    (ram_en0),
        .ram_wen_o   (ram_wen0),
        .ram_addr_o  (ram_addr0),
        .ram_wdata_o (ram_wdata0),
        .ram_rdata_i (ram_rdata0)
    );

    // Seed C160: a_stall pattern 0,1,1,1,0,x,0 and d_stall 1,1,1,0,0 from cycle 2.
    sram_like_responder #(.DEPTH(2), .RAND_EN(1'b1), .SEED(16'hC160)) dut1 (
        .clk         (clk),
        .reset       (rst1),
        .bus         (bus1),
        .ram_en_o    (ram_en1),
        .ram_wen_o   (ram_wen1),
        .ram_addr_o  (ram_addr1),
        .ram_wdata_o (ram_wdata1),
        .ram_rdata_i (ram_rdata1)
    );

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    always @(posedge clk) begin
        if (rst0) begin
            mem0[0]  <= 32'hCAFE_0000;
            mem0[1]  <= 32'h0BAD_0004;
            mem0[2]  <= 32'h5EED_0008;
            mem0[16] <= 32'h1111_1111;
            mem0[64] <= 32'h1234_5678;
        end else if (ram_en0) begin
            ram_rdata0 <= mem0[ram_addr0[9:2]];
            for (int b = 0; b < 4; b++)
                if (ram_wen0[b]) mem0[ram_addr0[9:2]][8*b +: 8] <= ram_wdata0[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (rst1) begin
            mem1[4] <= 32'hA000_0010;
            mem1[5] <= 32'hB000_0014;
            mem1[6] <= 32'hC000_0018;
        end else if (ram_en1) begin
            ram_rdata1 <= mem1[ram_addr1[9:2]];
            for (int b = 0; b < 4; b++)
                if (ram_wen1[b]) mem1[ram_addr1[9:2]][8*b +: 8] <= ram_wdata1[8*b +: 8];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step0(input logic rst, input logic req, input logic wr,
                         input logic [3:0] ws, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst0 = rst; bus0.req = req; bus0.wr = wr; bus0.wstrb = ws; bus0.addr = a; bus0.wdata = d;
        #1;
    endtask

    task automatic step1(input logic rst, input logic req, input logic [31:0] a);
        @(negedge clk);
        rst1 = rst; bus1.req = req; bus1.wr = 1'b0; bus1.wstrb = 4'h0; bus1.addr = a; bus1.wdata = 32'h0;
        #1;
    endtask

    initial begin
        bit          got;
        logic [31:0] rv;
        int          n_ok;

        rst0 = 1'b1; rst1 = 1'b1;
        bus0.req = 1'b0; bus0.wr = 1'b0; bus0.wstrb = 4'h0; bus0.addr = '0; bus0.wdata = '0;
        bus1.req = 1'b0; bus1.wr = 1'b0; bus1.wstrb = 4'h0; bus1.addr = '0; bus1.wdata = '0;

        // Reset with a write request pending: nothing may be issued.
        repeat (3) step0(1'b1, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
        chk("rst_addr_ok", bus0.addr_ok, 0);
        chk("rst_data_ok", bus0.data_ok, 0);
        chk("rst_rdata",   bus0.rdata,   0);
        chk("rst_ram_en",  ram_en0,      0);
        chk("rst_ram_wen", ram_wen0,     0);
        chk("rst1_addr_ok", bus1.addr_ok, 0);

        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("idle_addr_ok", bus0.addr_ok, 1);
        chk("idle_data_ok", bus0.data_ok, 0);

        // Single read of 0x100.
        step0(1'b0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        chk("rd1_addr_ok",  bus0.addr_ok, 1);
        chk("rd1_ram_en",   ram_en0,      1);
        chk("rd1_ram_wen",  ram_wen0,     0);
        chk("rd1_ram_addr", ram_addr0,    32'h100);
        chk("rd1_data_ok0", bus0.data_ok, 0);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rd1_data_ok1", bus0.data_ok, 0);
        chk("rd1_ram_en1",  ram_en0,      0);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rd1_data_ok2", bus0.data_ok, 1);
        chk("rd1_rdata",    bus0.rdata,   32'h1234_5678);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rd1_data_ok3", bus0.data_ok, 0);
        chk("rd1_rdata0",   bus0.rdata,   0);

        // Back-to-back reads 0x0, 0x4, 0x8.
        step0(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("b2b_acc0", bus0.addr_ok, 1);
        step0(1'b0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
        chk("b2b_acc1", bus0.addr_ok, 1);
        step0(1'b0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
        chk("b2b_acc2", bus0.addr_ok, 1);
        chk("b2b_dok0", bus0.data_ok, 1);
        chk("b2b_rd0",  bus0.rdata,   32'hCAFE_0000);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("b2b_dok1", bus0.data_ok, 1);
        chk("b2b_rd1",  bus0.rdata,   32'h0BAD_0004);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("b2b_dok2", bus0.data_ok, 1);
        chk("b2b_rd2",  bus0.rdata,   32'h5EED_0008);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("b2b_dok3", bus0.data_ok, 0);

        // Partial write to 0x40 then read back.
        step0(1'b0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hAABB_CCDD);
        chk("wr_addr_ok", bus0.addr_ok, 1);
        chk("wr_ram_en",  ram_en0,      1);
        chk("wr_ram_wen", ram_wen0,     4'b0011);
        chk("wr_wdata",   ram_wdata0,   32'hAABB_CCDD);
        step0(1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        chk("wrrd_addr_ok", bus0.addr_ok, 1);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("wr_dok",   bus0.data_ok, 1);
        chk("wr_rdata", bus0.rdata,   0);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("wrrd_dok",   bus0.data_ok, 1);
        chk("wrrd_rdata", bus0.rdata,   32'h1111_CCDD);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("wrrd_dok_end", bus0.data_ok, 0);

        // Reset while two reads are in flight.
        step0(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("mr_acc0", bus0.addr_ok, 1);
        step0(1'b0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
        chk("mr_acc1", bus0.addr_ok, 1);
        step0(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("mr_rst_dok",   bus0.data_ok, 0);
        chk("mr_rst_aok",   bus0.addr_ok, 0);
        chk("mr_rst_rdata", bus0.rdata,   0);
        for (int i = 0; i < 4; i++) begin
            step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            chk($sformatf("mr_post_dok%0d", i), bus0.data_ok, 0);
        end
        step0(1'b0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
        chk("mr_new_acc", bus0.addr_ok, 1);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("mr_new_dok1", bus0.data_ok, 0);
        step0(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("mr_new_dok2",  bus0.data_ok, 1);
        chk("mr_new_rdata", bus0.rdata,   32'h5EED_0008);

        // DEPTH=2 instance with stall injection.
        step1(1'b1, 1'b0, 32'h0);
        step1(1'b0, 1'b1, 32'h10);
        chk("d1_c0_aok", bus1.addr_ok, 1);
        chk("d1_c0_en",  ram_en1,      1);
        step1(1'b0, 1'b1, 32'h14);
        chk("d1_c1_aok", bus1.addr_ok, 0);
        chk("d1_c1_en",  ram_en1,      0);
        chk("d1_c1_dok", bus1.data_ok, 0);
        step1(1'b0, 1'b1, 32'h14);
        chk("d1_c2_aok", bus1.addr_ok, 0);
        chk("d1_c2_dok", bus1.data_ok, 0);
        step1(1'b0, 1'b1, 32'h14);
        chk("d1_c3_aok", bus1.addr_ok, 0);
        chk("d1_c3_dok", bus1.data_ok, 0);
        step1(1'b0, 1'b1, 32'h14);
        chk("d1_c4_aok", bus1.addr_ok, 1);
        chk("d1_c4_dok", bus1.data_ok, 0);
        // Outstanding limit reached: no accept even while a response leaves.
        step1(1'b0, 1'b1, 32'h18);
        chk("d1_c5_aok",   bus1.addr_ok, 0);
        chk("d1_c5_en",    ram_en1,      0);
        chk("d1_c5_dok",   bus1.data_ok, 1);
        chk("d1_c5_rdata", bus1.rdata,   32'hA000_0010);
        step1(1'b0, 1'b0, 32'h0);
        chk("d1_c6_en",    ram_en1,      0);
        chk("d1_c6_aok",   bus1.addr_ok, 1);
        chk("d1_c6_dok",   bus1.data_ok, 1);
        chk("d1_c6_rdata", bus1.rdata,   32'hB000_0014);
        n_ok = 0;
        for (int i = 0; i < 10; i++) begin
            step1(1'b0, 1'b0, 32'h0);
            if (bus1.data_ok || ram_en1) n_ok++;
        end
        chk("d1_withdrawn_quiet", n_ok, 0);

        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step1(1'b0, 1'b1, 32'h18);
            got = bus1.addr_ok;
        end
        chk("d1_c_accept", got, 1);
        got = 1'b0;
        rv  = 32'h0;
        for (int i = 0; i < 60 && !got; i++) begin
            step1(1'b0, 1'b0, 32'h0);
            if (bus1.data_ok) begin
                got = 1'b1;
                rv  = bus1.rdata;
            end
        end
        chk("d1_c_dok",   got, 1);
        chk("d1_c_rdata", rv,  32'hC000_0018);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
